// File: rtl/result_display_ctrl_if.sv
// Result-to-display bundle: capture strobe/byte in, conversion status and 7-seg drive out.
// Latency: none (wires only).
// Backpressure: none; the display side drops strobes that arrive while busy.
//
// Signals:
//   res_valid  one-cycle strobe qualifying res_data
//   res_data   8-bit result byte from the core output register
//   busy       conversion in progress
//   conv_done  one-cycle pulse when a new value becomes visible
//   seg        active-low segments {g,f,e,d,c,b,a}
//   an         active-low digit enables, an[0] = ones digit
//   dp         decimal point, active-low, always off
interface result_display_ctrl_if;
    logic       res_valid;
    logic [7:0] res_data;
    logic       busy;
    logic       conv_done;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    // master: the producer of results (core / bench)
    modport master (
        output res_valid, res_data,
        input  busy, conv_done, seg, an, dp
    );

    // slave: the display controller
    modport slave (
        input  res_valid, res_data,
        output busy, conv_done, seg, an, dp
    );
endinterface

// File: rtl/result_display_ctrl.sv
// Captures a result byte, converts it to BCD by sequential double-dabble, scans a 4-digit 7-seg display.
// Latency: 10 clk edges from the sampling edge of res_valid to the updated display registers.
// Backpressure: none; res_valid while busy is silently dropped.
//
// Ports:
//   i_clk   system clock (single domain)
//   i_rst   synchronous active-high reset
//   s_bus   result_display_ctrl_if.slave (res_valid/res_data in; busy/conv_done/seg/an/dp out)
// Parameters:
//   REFRESH_CNT    clk cycles each digit stays enabled (2..65535)
//   BLANK_LEADING  1 blanks leading zeros in hundreds/tens digits
// Optional macro SIGNED_DISPLAY_EN: treat res_data as two's complement and show a minus on digit 3.
module result_display_ctrl #(
    parameter int REFRESH_CNT   = 50000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    result_display_ctrl_if.slave  s_bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CNT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load;
    logic        w_commit;

    // {hundreds[19:16], tens[15:12], ones[11:8], binary[7:0]}
    logic [19:0] r_shift;
    logic [19:0] w_adj;
    logic [2:0]  r_bitcnt;
    logic [7:0]  w_mag;

    logic [3:0]  r_hund;
    logic [3:0]  r_tens;
    logic [3:0]  r_ones;
    logic        r_conv_done;

    logic [15:0] r_refresh;
    logic [1:0]  r_digit;
    logic [6:0]  r_seg;
    logic [3:0]  r_an;
    logic [6:0]  w_seg_sel;
    logic        w_minus;

    function automatic logic [3:0] f_add3(input logic [3:0] i_nib);
        return (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
    endfunction

    function automatic logic [6:0] f_seg7(input logic [3:0] i_bcd);
        logic [6:0] v;
        case (i_bcd)
            4'd0:    v = 7'h40;
            4'd1:    v = 7'h79;
            4'd2:    v = 7'h24;
            4'd3:    v = 7'h30;
            4'd4:    v = 7'h19;
            4'd5:    v = 7'h12;
            4'd6:    v = 7'h02;
            4'd7:    v = 7'h78;
            4'd8:    v = 7'h00;
            4'd9:    v = 7'h10;
            default: v = 7'h7F;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Magnitude and sign of the incoming byte
    // ------------------------------------------------------------------
`ifdef SIGNED_DISPLAY_EN
    logic r_sign;
    logic w_neg;

    // 0x80 negates to 0x80, which reads as 128 unsigned: exactly what we want.
    assign w_neg   = s_bus.res_data[7];
    assign w_mag   = w_neg ? (~s_bus.res_data + 8'd1) : s_bus.res_data;
    assign w_minus = r_sign;

    // The sign is taken at capture time, so the minus tracks the value being
    // converted rather than waiting for the digits to commit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sign <= 1'b0;
        end else if (w_load) begin
            r_sign <= w_neg;
        end
    end
`else
    assign w_mag   = s_bus.res_data;
    assign w_minus = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_bus.res_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_bitcnt == 3'd7) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One double-dabble step: correct each BCD nibble, then shift left.
    assign w_adj = {f_add3(r_shift[19:16]), f_add3(r_shift[15:12]),
                    f_add3(r_shift[11:8]), r_shift[7:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift     <= 20'd0;
            r_bitcnt    <= 3'd0;
            r_hund      <= 4'd0;
            r_tens      <= 4'd0;
            r_ones      <= 4'd0;
            r_conv_done <= 1'b0;
        end else begin
            r_conv_done <= w_commit;
            if (w_load) begin
                r_shift  <= {12'd0, w_mag};
                r_bitcnt <= 3'd0;
            end else if (r_state == ST_SHIFT) begin
                r_shift  <= w_adj << 1;
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_commit) begin
                r_hund <= r_shift[19:16];
                r_tens <= r_shift[15:12];
                r_ones <= r_shift[11:8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Digit scan: free-running, independent of the conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_refresh <= 16'd0;
            r_digit   <= 2'd0;
        end else if (r_refresh == REFRESH_LAST) begin
            r_refresh <= 16'd0;
            r_digit   <= r_digit + 2'd1;
        end else begin
            r_refresh <= r_refresh + 16'd1;
        end
    end

    always_comb begin
        w_seg_sel = SEG_BLANK;
        case (r_digit)
            2'd0: w_seg_sel = f_seg7(r_ones);
            2'd1: w_seg_sel = (BLANK_LEADING && (r_hund == 4'd0) && (r_tens == 4'd0))
                              ? SEG_BLANK : f_seg7(r_tens);
            2'd2: w_seg_sel = (BLANK_LEADING && (r_hund == 4'd0))
                              ? SEG_BLANK : f_seg7(r_hund);
            2'd3: w_seg_sel = w_minus ? SEG_MINUS : SEG_BLANK;
            default: w_seg_sel = SEG_BLANK;
        endcase
    end

    // Registered drive: anode and segments change together, one cycle after the index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_an  <= 4'hF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(4'b0001 << r_digit);
            r_seg <= w_seg_sel;
        end
    end

    assign s_bus.busy      = (r_state != ST_IDLE);
    assign s_bus.conv_done = r_conv_done;
    assign s_bus.seg       = r_seg;
    assign s_bus.an        = r_an;
    assign s_bus.dp        = 1'b1;

endmodule

// File: tb/tb_result_display_ctrl.sv
// Bench for result_display_ctrl: two instances (leading-zero blanking on and off) share stimulus.
// Expected outputs come from an arithmetic model: edge counting for the scan, a countdown for conversion.
// Directed cases first, then randomized strobes, data and occasional resets.
module tb_result_display_ctrl;

    localparam int RC = 4;
    localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst;
    logic       tb_valid;
    logic [7:0] tb_data;

    always #5 clk = ~clk;

    result_display_ctrl_if bus_a ();
    result_display_ctrl_if bus_b ();

    assign bus_a.res_valid = tb_valid;
    assign bus_a.res_data  = tb_data;
    assign bus_b.res_valid = tb_valid;
    assign bus_b.res_data  = tb_data;

    result_display_ctrl #(.REFRESH_CNT(RC), .BLANK_LEADING(1'b1)) u_dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (bus_a)
    );

    result_display_ctrl #(.REFRESH_CNT(RC), .BLANK_LEADING(1'b0)) u_dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .s_bus (bus_b)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int n_edges   = 0;   // edges since reset released
    int remaining = 0;   // edges until the pending value is shown; 0 = idle
    int disp_mag  = 0;
    int pend_mag  = 0;
    bit sign_now  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_seg(input int dig, input int mag, input bit neg, input bit blank);
        int h, t, o;
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        case (dig)
            0: return SEG_TAB[o];
            1: return (blank && h == 0 && t == 0) ? 7'h7F : SEG_TAB[t];
            2: return (blank && h == 0) ? 7'h7F : SEG_TAB[h];
            default: return neg ? 7'h3F : 7'h7F;
        endcase
    endfunction

    // Apply inputs for one edge, advance the model across that edge, then check all outputs.
    task automatic step(input bit r, input bit v, input logic [7:0] d);
        logic [3:0] e_an;
        logic [6:0] e_seg_a, e_seg_b;
        bit         e_done;
        int         dig;
        rst      = r;
        tb_valid = v;
        tb_data  = d;
        @(posedge clk);
        e_done = 1'b0;
        if (r) begin
            e_an      = 4'hF;
            e_seg_a   = 7'h7F;
            e_seg_b   = 7'h7F;
            n_edges   = 0;
            remaining = 0;
            disp_mag  = 0;
            sign_now  = 1'b0;
        end else begin
            dig     = (n_edges / RC) % 4;
            e_an    = ~(4'b0001 << dig);
            e_seg_a = model_seg(dig, disp_mag, sign_now, 1'b1);
            e_seg_b = model_seg(dig, disp_mag, sign_now, 1'b0);
            n_edges++;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    disp_mag = pend_mag;
                    e_done   = 1'b1;
                end
            end else if (v) begin
`ifdef SIGNED_DISPLAY_EN
                if (d[7]) begin
                    pend_mag = 256 - int'(d);
                    sign_now = 1'b1;
                end else begin
                    pend_mag = int'(d);
                    sign_now = 1'b0;
                end
`else
                pend_mag = int'(d);
`endif
                remaining = 9;
            end
        end
        #1;
        chk("an_a",   bus_a.an,        e_an);
        chk("an_b",   bus_b.an,        e_an);
        chk("seg_a",  bus_a.seg,       e_seg_a);
        chk("seg_b",  bus_b.seg,       e_seg_b);
        chk("busy",   bus_a.busy,      (remaining > 0));
        chk("busy_b", bus_b.busy,      (remaining > 0));
        chk("done",   bus_a.conv_done, e_done);
        chk("done_b", bus_b.conv_done, e_done);
        chk("dp",     bus_a.dp,        1'b1);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset and idle scan
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
        idle(40);

        // Full-scale value, then let every digit scan past
        step(1'b0, 1'b1, 8'hFF);
        idle(30);

        // Leading-zero case
        step(1'b0, 1'b1, 8'h07);
        idle(30);

        // Second strobe while busy is dropped
        step(1'b0, 1'b1, 8'h2A);
        idle(2);
        step(1'b0, 1'b1, 8'h10);
        idle(30);

        // Negative values (plain unsigned in the default build)
        step(1'b0, 1'b1, 8'hF6);
        idle(30);
        step(1'b0, 1'b1, 8'h80);
        idle(30);

        // Reset mid-conversion, then a fresh conversion
        step(1'b0, 1'b1, 8'h63);
        idle(3);
        step(1'b1, 1'b0, 8'h00);
        idle(2);
        step(1'b0, 1'b1, 8'h05);
        idle(30);

        // Strobe exactly at the first edge after conv_done
        step(1'b0, 1'b1, 8'h99);
        idle(9);
        step(1'b0, 1'b1, 8'h64);
        idle(20);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0), 8'($urandom));
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_display_ctrl.md
Name: result_display_ctrl

Overview:
- Downstream consumer of the processor's 8-bit output register, the value currently driven onto `led`.
- Captures a result on a valid strobe and converts it to BCD with a sequential double-dabble engine.
- Drives a 4-digit, active-low, common-anode seven-segment display by time-multiplexing the digits.
- Decouples the core's halt-time result from the board display.

Parameters:
- REFRESH_CNT, 50000: clk cycles each digit stays enabled (legal range 2..65535).
- BLANK_LEADING, 1: 1 blanks leading zeros in the hundreds and tens digits; 0 shows all three digits.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  one-cycle strobe; res_data is valid in this cycle.
- res_data  in  8  result byte from the core's output register.
- busy  out  1  high while a conversion is in progress (state != IDLE).
- conv_done  out  1  one-cycle pulse when the new value becomes visible.
- seg  out  7  active-low segments, {g,f,e,d,c,b,a}.
- an  out  4  active-low digit enables; an[0] = ones, an[3] = leftmost.
- dp  out  1  decimal point, held at 1 (off).

Behaviour:
- Reset values: seg=7'h7F, an=4'hF, dp=1, busy=0, conv_done=0, displayed BCD=000, sign=0, digit index=0, refresh counter=0, state=IDLE.
- Reset applies in any state. A reset mid-conversion aborts it, gives no conv_done, and the display reverts to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, at an edge E0 with res_valid=1:
  - load shift register {bcd[11:0]=0, bin[7:0]=res_data};
  - bit counter=0;
  - go to SHIFT.
- SHIFT, edges E1..E8, one iteration per edge:
  - add 3 to each BCD nibble that is >=5, then shift the 20-bit register left by 1;
  - at E8 (counter=7), go to DONE.
- DONE, edge E9:
  - copy the BCD (hundreds, tens, ones) into the display registers;
  - conv_done<=1; state<=IDLE.
- E10: conv_done<=0. Conversion latency is 10 edges from the sampling edge to the updated display.
- res_valid while busy=1 is dropped silently. A res_valid sampled at E10 or later starts a new conversion.
- The hundreds nibble never exceeds 2 (unsigned) and never exceeds 1 with a magnitude of 128 (signed).
- Refresh:
  - free-running counter 0..REFRESH_CNT-1; on wrap, the 2-bit digit index increments 0->1->2->3->0;
  - it is independent of the FSM and keeps scanning during conversion, showing the old value until E9.
- Output registers:
  - an, seg are registered from the digit index and display registers, with one cycle of lag;
  - an has exactly one bit low at any time after the first post-reset cycle.
- Digit content:
  - digit 0: ones, always shown;
  - digit 1: tens, blank if BLANK_LEADING=1 and hundreds=0 and tens=0;
  - digit 2: hundreds, blank if BLANK_LEADING=1 and hundreds=0;
  - digit 3: blank (7'h7F), except the sign case under the optional feature.
- Segment codes, seg hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10;
  - minus=3F, blank=7F.

Optional Feature:
- Macro SIGNED_DISPLAY_EN.
- When defined:
  - res_data is two's complement;
  - at E0, if bit7=1, sign<=1 and the magnitude loaded is (~res_data+1) on 8 bits (0x80 gives 128);
  - digit 3 shows minus (3F) when sign=1.
- When undefined:
  - res_data is unsigned 0..255;
  - no sign register exists; digit 3 is always blank.

Test Plan (bench uses REFRESH_CNT=4):
- Reset, then 40 idle cycles -> an scans E,D,B,7 every 4 cycles; seg=40 on an=E; seg=7F on the other digits; busy=0; conv_done never high.
- res_valid with 0xFF (unsigned) -> busy high for edges E1..E9; conv_done=1 for exactly 1 cycle after E9; digits 2,1,0 show 24,12,12 (255).
- res_valid with 0x07 -> ones=78, tens and hundreds=7F; with BLANK_LEADING=0 -> tens=40, hundreds=40.
- res_valid with 0x2A, then res_valid with 0x10 at E3 -> display 42 (tens=19, ones=24); exactly one conv_done pulse.
- SIGNED_DISPLAY_EN, res_data=0xF6 -> digit3=3F, tens=79, ones=40 (-10). res_data=0x80 -> digit3=3F, hundreds=79, tens=24, ones=00 (-128).
- Load 0x63, then assert rst at E4 -> busy=0 and display 0 on the next edge; no conv_done; a fresh 0x05 after rst deasserts converts normally.
